// File: rtl/viterbi_bist_gen_if.sv
// Symbol / decoded-bit link between the BIST generator (master) and a Viterbi decoder (slave).
interface viterbi_bist_gen_if;
    logic       sym_valid;
    logic       sym_ready;
    logic [1:0] sym;
    logic       force_state0;
    logic       dec_valid;
    logic       dec_bit;

    modport master (output sym_valid, sym, force_state0, input  sym_ready, dec_valid, dec_bit);
    modport slave  (input  sym_valid, sym, force_state0, output sym_ready, dec_valid, dec_bit);
endinterface

// File: rtl/viterbi_bist_gen.sv
// PRBS -> convolutional encoder -> decoder stimulus, with a reference FIFO checking decoded bits.
// Optional VBIST_LATENCY_MON_EN adds lat_first (first handshake to first dec_valid, in cycles).
module viterbi_bist_gen #(
    parameter int          K         = 3,
    parameter logic [7:0]  G0_OCT    = 8'o07,
    parameter logic [7:0]  G1_OCT    = 8'o05,
    parameter int          REF_DEPTH = 64,
    parameter int          TIMEOUT   = 4096,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] num_bits,
    input  logic [7:0]  err_period,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] bit_count,
    output logic [15:0] err_count,
`ifdef VBIST_LATENCY_MON_EN
    output logic [15:0] lat_first,
`endif
    viterbi_bist_gen_if.master link
);
    localparam int M  = K - 1;
    localparam int AW = $clog2(REF_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [K-1:0]  G0      = G0_OCT[K-1:0];
    localparam logic [K-1:0]  G1      = G1_OCT[K-1:0];
    localparam logic [CW-1:0] DEPTH_C = CW'(REF_DEPTH);
    localparam logic [WW-1:0] WD_LIM  = WW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_n;
    logic [15:0]     nb_q, nb_n, prbs_q, prbs_n;
    logic [7:0]      per_q, per_n, pcnt_q, pcnt_n;
    logic [M-1:0]    enc_q, enc_n;
    logic [16:0]     idx_q, idx_n, total_q;
    logic [1:0]      sym_q, sym_d;
    logic            vld_q, vld_d;
    logic [WW-1:0]   wd_q, wd_n;
    logic            to_set;
    logic [REF_DEPTH-1:0] mem_q;
    logic [AW-1:0]   wp_q, rp_q;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            clr, hs, pop, chk, mism, u_cur, u_n, inj_n;
    logic [K-1:0]    reg_cur, reg_n;

    assign clr     = (state_q == S_IDLE) && start;
    assign hs      = vld_q && link.sym_ready;
    assign total_q = {1'b0, nb_q} + 17'(M);
    assign u_cur   = (idx_q < {1'b0, nb_q}) ? prbs_q[0] : 1'b0;
    assign reg_cur = {u_cur, enc_q};

    assign chk  = link.dec_valid && (state_q != S_IDLE) && (bit_count < nb_q);
    assign pop  = chk && (cnt_q != '0);
    assign mism = chk && ((cnt_q == '0) || (mem_q[rp_q] != link.dec_bit));

    assign busy              = (state_q != S_IDLE);
    assign link.force_state0 = busy;
    assign link.sym          = sym_q;
    assign link.sym_valid    = vld_q;

    always_comb begin
        state_n = state_q;
        prbs_n  = prbs_q;
        enc_n   = enc_q;
        idx_n   = idx_q;
        pcnt_n  = pcnt_q;
        wd_n    = wd_q;
        to_set  = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                prbs_n  = SEED;
                enc_n   = '0;
                idx_n   = '0;
                pcnt_n  = 8'd1;
                state_n = (num_bits == 16'd0) ? S_DONE : S_SEND;
            end
            S_SEND: begin
                wd_n = '0;
                if (hs) begin
                    prbs_n = {prbs_q[0] ^ prbs_q[2] ^ prbs_q[3] ^ prbs_q[5], prbs_q[15:1]};
                    enc_n  = reg_cur[K-1:1];
                    idx_n  = idx_q + 17'd1;
                    pcnt_n = (pcnt_q == per_q) ? 8'd1 : pcnt_q + 8'd1;
                    if (idx_n == total_q) state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bit_count == nb_q) state_n = S_DONE;
                else if (link.dec_valid) wd_n = '0;
                else begin
                    wd_n = wd_q + 1'b1;
                    if (wd_n == WD_LIM) begin
                        to_set  = 1'b1;
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // The presented symbol is always the encoding of the *next* register contents, so it
    // only changes when those registers do, i.e. on a handshake or at run start.
    assign nb_n  = clr ? num_bits : nb_q;
    assign per_n = clr ? err_period : per_q;
    assign cnt_n = clr ? '0 : cnt_q + CW'(hs) - CW'(pop);
    assign u_n   = (idx_n < {1'b0, nb_n}) ? prbs_n[0] : 1'b0;
    assign reg_n = {u_n, enc_n};
    assign inj_n = (per_n != 8'd0) && (pcnt_n == per_n);
    assign sym_d = {^(reg_n & G0), ^(reg_n & G1) ^ inj_n};
    assign vld_d = (state_n == S_SEND) && (cnt_n < DEPTH_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            nb_q      <= '0;
            per_q     <= '0;
            prbs_q    <= SEED;
            enc_q     <= '0;
            idx_q     <= '0;
            pcnt_q    <= '0;
            sym_q     <= '0;
            vld_q     <= 1'b0;
            wd_q      <= '0;
            mem_q     <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            bit_count <= '0;
            err_count <= '0;
        end else begin
            state_q <= state_n;
            nb_q    <= nb_n;
            per_q   <= per_n;
            prbs_q  <= prbs_n;
            enc_q   <= enc_n;
            idx_q   <= idx_n;
            pcnt_q  <= pcnt_n;
            sym_q   <= sym_d;
            vld_q   <= vld_d;
            wd_q    <= wd_n;
            cnt_q   <= cnt_n;
            done    <= (state_q == S_DONE);
            if (hs) mem_q[wp_q] <= u_cur;
            if (clr) begin
                wp_q      <= '0;
                rp_q      <= '0;
                bit_count <= '0;
                err_count <= '0;
                pass      <= 1'b0;
                timeout   <= 1'b0;
            end else begin
                if (hs)  wp_q <= wp_q + 1'b1;
                if (pop) rp_q <= rp_q + 1'b1;
                if (chk) bit_count <= bit_count + 16'd1;
                if (mism && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
                if (to_set) timeout <= 1'b1;
                if (state_q == S_DONE)
                    pass <= (bit_count == nb_q) && (err_count == 16'd0) && !timeout;
            end
        end
    end

`ifdef VBIST_LATENCY_MON_EN
    logic lat_arm_q, lat_got_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_first <= '0;
            lat_arm_q <= 1'b0;
            lat_got_q <= 1'b0;
        end else if (clr) begin
            lat_first <= '0;
            lat_arm_q <= 1'b0;
            lat_got_q <= 1'b0;
        end else if (!lat_got_q && (lat_arm_q || hs)) begin
            lat_arm_q <= 1'b1;
            if (link.dec_valid)           lat_got_q <= 1'b1;
            else if (lat_first != 16'hFFFF) lat_first <= lat_first + 16'd1;
        end
    end
`endif
endmodule
